// File: rtl/multicycle_alu.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_alu
// Purpose  : Valid/ready ALU. Most opcodes finish one edge after accept; the
//            unsigned divide and remainder opcodes run a restoring divider
//            that produces one quotient bit per cycle.
// Ports    : i_clk, i_reset           clock, synchronous active-high reset
//            i_valid / o_ready        request handshake
//            i_op, i_arg_A, i_arg_B   opcode and operands, sampled at accept
//            o_valid / i_ready        result handshake
//            o_result, o_status       result and flags {parity,err,ovf,zero}
// Revision : 1.0  initial release
// ============================================================================
module multicycle_alu #(
    parameter int N = 4,
    parameter int M = 8
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [N-1:0] i_op,
    input  logic [M-1:0] i_arg_A,
    input  logic [M-1:0] i_arg_B,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [M-1:0] o_result,
    output logic [3:0]   o_status
);

    localparam int          CNT_W     = $clog2(M);
    localparam logic [1:0]  S_IDLE    = 2'd0;
    localparam logic [1:0]  S_DIV     = 2'd1;
    localparam logic [1:0]  S_DONE    = 2'd2;
    localparam logic [M-1:0] C_ONE    = M'(1);
    localparam logic [M-1:0] C_WIDTH  = M'(M);
    localparam logic [M-1:0] C_MIN    = {1'b1, {(M-1){1'b0}}};
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(M - 1);

    logic [1:0]       r_state;
    logic [M-1:0]     r_result;
    logic [3:0]       r_status;
    logic [M-1:0]     r_rem;
    logic [M-1:0]     r_quot;
    logic [M-1:0]     r_divisor;
    logic             r_is_mod;
    logic [CNT_W-1:0] r_cnt;

    logic [3:0]   w_op;
    logic         w_unused_op;
    logic         w_is_div;
    logic         w_b_zero;
    logic [M-1:0] w_add;
    logic [M-1:0] w_sub;
    logic [M-1:0] w_mag;
    logic [M-1:0] w_mag_neg;
    logic [M-1:0] w_a_neg;
    logic [M-1:0] w_res;
    logic         w_ovf;
    logic         w_err;

    logic [M:0]   w_div_shift;
    logic [M:0]   w_div_trial;
    logic         w_div_ge;
    logic [M-1:0] w_rem_next;
    logic [M-1:0] w_quot_next;
    logic [M-1:0] w_div_res;

    function automatic logic [3:0] f_flags(input logic [M-1:0] res,
                                           input logic ovf, input logic err);
        f_flags = {^res, err, ovf, (res == '0)};
    endfunction

    // Only the low four opcode bits carry meaning; the rest are folded away.
    assign w_op        = i_op[3:0];
    assign w_unused_op = ^i_op;
    assign w_is_div    = (w_op[3:1] == 3'b001);
    assign w_b_zero    = (i_arg_B == '0);

    assign w_add     = i_arg_A + i_arg_B;
    assign w_sub     = i_arg_A - i_arg_B;
    assign w_mag     = {1'b0, i_arg_A[M-2:0]};
    assign w_mag_neg = ~w_mag + C_ONE;
    assign w_a_neg   = ~i_arg_A + C_ONE;

    // Single-cycle results, also covering the divide-by-zero shortcut.
    always_comb begin
        w_res = '0;
        w_ovf = 1'b0;
        w_err = 1'b0;
        case (w_op)
            4'h0: begin
                w_res = w_add;
                w_ovf = (i_arg_A[M-1] == i_arg_B[M-1]) && (w_add[M-1] != i_arg_A[M-1]);
            end
            4'h1: begin
                w_res = w_sub;
                w_ovf = (i_arg_A[M-1] != i_arg_B[M-1]) && (w_sub[M-1] != i_arg_A[M-1]);
            end
            4'h2: begin
                w_res = '1;
                w_err = 1'b1;
            end
            4'h3: begin
                w_res = i_arg_A;
                w_err = 1'b1;
            end
            4'h4: w_res = (i_arg_B >= C_WIDTH) ? '0 : (i_arg_A >> i_arg_B);
            4'h5: w_res = {{(M-1){1'b0}}, ($signed(i_arg_A) < $signed(i_arg_B))};
            // Sign-magnitude negative zero maps naturally to 0 here.
            4'h6: w_res = i_arg_A[M-1] ? w_mag_neg : i_arg_A;
            4'h7: begin
                if (i_arg_A == C_MIN) begin
                    // Most negative value has no sign-magnitude form.
                    w_res = i_arg_A;
                    w_ovf = 1'b1;
                end else if (i_arg_A[M-1]) begin
                    w_res = {1'b1, w_a_neg[M-2:0]};
                end else begin
                    w_res = i_arg_A;
                end
            end
            default: w_err = 1'b1;
        endcase
    end

    // Restoring divider step. The partial remainder is always below the
    // divisor, so the shifted value fits in M+1 bits and the top bit of the
    // trial subtraction is a borrow flag.
    assign w_div_shift = {r_rem, r_quot[M-1]};
    assign w_div_trial = w_div_shift - {1'b0, r_divisor};
    assign w_div_ge    = ~w_div_trial[M];
    assign w_rem_next  = w_div_ge ? w_div_trial[M-1:0] : w_div_shift[M-1:0];
    assign w_quot_next = {r_quot[M-2:0], w_div_ge};
    assign w_div_res   = r_is_mod ? w_rem_next : w_quot_next;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state   <= S_IDLE;
            r_result  <= '0;
            r_status  <= '0;
            r_rem     <= '0;
            r_quot    <= '0;
            r_divisor <= '0;
            r_is_mod  <= 1'b0;
            r_cnt     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_valid) begin
                        if (w_is_div && !w_b_zero) begin
                            r_state   <= S_DIV;
                            r_rem     <= '0;
                            r_quot    <= i_arg_A;
                            r_divisor <= i_arg_B;
                            r_is_mod  <= w_op[0];
                            r_cnt     <= '0;
                        end else begin
                            r_state  <= S_DONE;
                            r_result <= w_res;
                            r_status <= f_flags(w_res, w_ovf, w_err);
                        end
                    end
                end
                S_DIV: begin
                    r_rem  <= w_rem_next;
                    r_quot <= w_quot_next;
                    r_cnt  <= r_cnt + 1'b1;
                    if (r_cnt == C_LAST) begin
                        r_state  <= S_DONE;
                        r_result <= w_div_res;
                        r_status <= f_flags(w_div_res, 1'b0, 1'b0);
                    end
                end
                S_DONE: begin
                    if (i_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_ready  = (r_state == S_IDLE);
    assign o_valid  = (r_state == S_DONE);
    assign o_result = r_result;
    assign o_status = r_status;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_alu.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_multicycle_alu
// Purpose  : Self-checking bench for multicycle_alu (N=6, M=8) with a
//            behavioural reference model and directed vectors.
// Revision : 1.0  initial release
// ============================================================================
module tb_multicycle_alu;

    localparam int N = 6;
    localparam int M = 8;

    logic         clk     = 1'b0;
    logic         rst     = 1'b1;
    logic         i_valid = 1'b0;
    logic         i_ready = 1'b0;
    logic [N-1:0] i_op    = '0;
    logic [M-1:0] arg_a   = '0;
    logic [M-1:0] arg_b   = '0;
    wire          o_ready;
    wire          o_valid;
    wire  [M-1:0] o_result;
    wire  [3:0]   o_status;

    always #5 clk = ~clk;

    multicycle_alu #(.N(N), .M(M)) dut (
        .i_clk    (clk),
        .i_reset  (rst),
        .i_valid  (i_valid),
        .o_ready  (o_ready),
        .i_op     (i_op),
        .i_arg_A  (arg_a),
        .i_arg_B  (arg_b),
        .o_valid  (o_valid),
        .i_ready  (i_ready),
        .o_result (o_result),
        .o_status (o_status)
    );

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference arithmetic: what each opcode must produce, plus its latency.
    function automatic void model_op(input logic [3:0] op, input logic [7:0] a,
                                     input logic [7:0] b, output logic [7:0] r,
                                     output logic [3:0] st, output int lat);
        int  sa, sb, s;
        bit  ovf, err;
        sa = $signed(a);
        sb = $signed(b);
        ovf = 0; err = 0; lat = 1; r = 8'h00;
        case (op)
            4'd0: begin s = sa + sb; r = 8'(s); ovf = (s > 127) || (s < -128); end
            4'd1: begin s = sa - sb; r = 8'(s); ovf = (s > 127) || (s < -128); end
            4'd2: if (b == 0) begin r = 8'hFF; err = 1; end else begin r = a / b; lat = M + 1; end
            4'd3: if (b == 0) begin r = a;     err = 1; end else begin r = a % b; lat = M + 1; end
            4'd4: r = (b >= 8) ? 8'h00 : (a >> b);
            4'd5: r = (sa < sb) ? 8'h01 : 8'h00;
            4'd6: begin s = a & 8'h7F; r = a[7] ? 8'(-s) : a; end
            4'd7: begin
                if (a == 8'h80) begin r = 8'h80; ovf = 1; end
                else if (a[7]) r = 8'h80 | 8'(-sa);
                else r = a;
            end
            default: begin r = 8'h00; err = 1; end
        endcase
        st = {^r, err, ovf, (r == 8'h00)};
    endfunction

    // Transaction-level model: tracks readiness, pending latency and the
    // currently presented result.
    logic       m_ready = 1'b1;
    logic       m_valid = 1'b0;
    logic [7:0] m_res   = '0;
    logic [3:0] m_stat  = '0;
    logic [7:0] p_res   = '0;
    logic [3:0] p_stat  = '0;
    int         m_wait  = 0;

    always @(posedge clk) begin
        logic [7:0] r;
        logic [3:0] st;
        int         lat;
        if (rst) begin
            m_ready = 1'b1; m_valid = 1'b0; m_res = '0; m_stat = '0; m_wait = 0;
        end else if (m_valid) begin
            if (i_ready) begin m_valid = 1'b0; m_ready = 1'b1; end
        end else if (m_wait > 0) begin
            m_wait--;
            if (m_wait == 0) begin m_valid = 1'b1; m_res = p_res; m_stat = p_stat; end
        end else if (i_valid) begin
            model_op(i_op[3:0], arg_a, arg_b, r, st, lat);
            m_ready = 1'b0;
            if (lat == 1) begin m_valid = 1'b1; m_res = r; m_stat = st; end
            else begin m_wait = lat - 1; p_res = r; p_stat = st; end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("o_ready",  o_ready,  m_ready);
            check("o_valid",  o_valid,  m_valid);
            check("o_result", o_result, m_res);
            check("o_status", o_status, m_stat);
        end
    end

    task automatic junk();
        i_valid = 1'b1;
        i_op    = N'($urandom);
        arg_a   = 8'($urandom);
        arg_b   = 8'($urandom);
    endtask

    // Issue one request, keep the inputs noisy while busy, hold i_ready low
    // for `hold` cycles of DONE, then take the result.
    task automatic do_op(input logic [3:0] op, input logic [7:0] va, input logic [7:0] vb,
                         input int hold, output int lat);
        int k;
        k = 0;
        while (!m_ready && k < 50) begin @(negedge clk); k++; end
        i_valid = 1'b1;
        i_op    = {2'($urandom), op};
        arg_a   = va;
        arg_b   = vb;
        @(negedge clk);
        lat = 1;
        while (!o_valid && lat < 40) begin junk(); @(negedge clk); lat++; end
        check("result_arrives", o_valid, 1'b1);
        for (int h = 0; h < hold; h++) begin junk(); @(negedge clk); end
        junk();
        i_ready = 1'b1;
        @(negedge clk);
        i_ready = 1'b0;
        i_valid = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int lat;
        @(negedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        check("rst_ready",  o_ready,  1'b1);
        check("rst_valid",  o_valid,  1'b0);
        check("rst_result", o_result, 8'h00);
        check("rst_status", o_status, 4'h0);
        rst = 1'b0;
        @(negedge clk);

        do_op(4'h0, 8'h7F, 8'h01, 0, lat);
        check("add_lat",    lat,      1);
        check("add_result", o_result, 8'h80);
        check("add_status", o_status, 4'b1010);

        do_op(4'h2, 8'd13, 8'd3, 0, lat);
        check("div_lat",    lat,      9);
        check("div_result", o_result, 8'h04);
        do_op(4'h3, 8'd13, 8'd3, 0, lat);
        check("mod_lat",    lat,      9);
        check("mod_result", o_result, 8'h01);

        do_op(4'h2, 8'd5, 8'd0, 0, lat);
        check("div0_lat",    lat,      1);
        check("div0_result", o_result, 8'hFF);
        check("div0_status", o_status, 4'b0100);
        do_op(4'h3, 8'd5, 8'd0, 0, lat);

        do_op(4'h6, 8'h8A, 8'h00, 0, lat);
        check("sm2u2_result", o_result, 8'hF6);
        do_op(4'h7, 8'h80, 8'h00, 0, lat);
        check("u22sm_min_result", o_result, 8'h80);
        check("u22sm_min_ovf",    o_status[1], 1'b1);
        do_op(4'h6, 8'h80, 8'h00, 0, lat);
        check("negzero_result", o_result, 8'h00);
        check("negzero_status", o_status, 4'b0001);
        do_op(4'h7, 8'hF6, 8'h00, 0, lat);

        do_op(4'h1, 8'h80, 8'h01, 0, lat);
        do_op(4'h4, 8'hF0, 8'd4, 0, lat);
        do_op(4'h4, 8'hF0, 8'd8, 0, lat);
        do_op(4'h4, 8'hF0, 8'hFF, 0, lat);
        do_op(4'h5, 8'h80, 8'h01, 0, lat);
        do_op(4'h5, 8'h05, 8'h03, 0, lat);
        do_op(4'hA, 8'h12, 8'h34, 0, lat);
        check("undef_status", o_status, 4'b0101);
        do_op(4'h2, 8'hFF, 8'h01, 0, lat);
        do_op(4'h2, 8'd7, 8'd200, 0, lat);
        do_op(4'h3, 8'hFF, 8'd10, 0, lat);

        // Held result while the consumer stalls.
        do_op(4'h0, 8'h12, 8'h34, 3, lat);
        check("hold_result", o_result, 8'h46);

        // Reset during the 4th divider cycle aborts the operation.
        i_valid = 1'b1; i_op = 6'h02; arg_a = 8'd13; arg_b = 8'd3;
        @(negedge clk);
        i_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_ready",  o_ready,  1'b1);
        check("abort_valid",  o_valid,  1'b0);
        check("abort_result", o_result, 8'h00);
        check("abort_status", o_status, 4'h0);
        repeat (12) @(negedge clk);

        // Reset wins over a simultaneous accept.
        do_op(4'h0, 8'h01, 8'h02, 0, lat);
        i_valid = 1'b1; i_op = 6'h00; arg_a = 8'h05; arg_b = 8'h06; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; i_valid = 1'b0;
        check("rst_accept_ready",  o_ready,  1'b1);
        check("rst_accept_result", o_result, 8'h00);

        // Reset wins over i_ready in DONE.
        i_valid = 1'b1; i_op = 6'h00; arg_a = 8'h01; arg_b = 8'h01;
        @(negedge clk);
        i_valid = 1'b0; i_ready = 1'b1; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; i_ready = 1'b0;
        repeat (3) @(negedge clk);

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/multicycle_alu.md
MULTICYCLE_ALU -- requirements
Module: multicycle_alu

Interface
REQ-001 Parameter N, default 4, opcode width; SHALL be >= 4, and opcode bits above [3] SHALL be ignored.
REQ-002 Parameter M, default 8, operand and result width; SHALL be >= 4.
REQ-003 i_clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-004 i_reset  in  1  reset, synchronous and active-high.
REQ-005 i_valid  in  1  request valid.
REQ-006 o_ready  out  1  block can accept a request.
REQ-007 i_op  in  N  opcode, sampled at accept.
REQ-008 i_arg_A  in  M  operand A, sampled at accept.
REQ-009 i_arg_B  in  M  operand B, sampled at accept.
REQ-010 o_valid  out  1  result valid.
REQ-011 i_ready  in  1  consumer takes the result.
REQ-012 o_result  out  M  result.
REQ-013 o_status  out  4  flags: [0] zero, [1] overflow, [2] error, [3] odd parity of o_result.

Function
REQ-014 FSM states SHALL be IDLE, DIV and DONE; o_ready=1 only in IDLE, and o_valid=1 only in DONE.
REQ-015 Accept SHALL occur on an edge where i_valid & o_ready; operands and opcode are latched, and later input changes SHALL be ignored.
REQ-016 Opcodes: 0000 A+B; 0001 A-B; 0010 A/B unsigned quotient; 0011 A%B unsigned remainder; 0100 A>>B logical; 0101 signed A<B (result 1 or 0); 0110 sign-magnitude A to U2; 0111 U2 A to sign-magnitude.
REQ-017 Non-divide opcodes SHALL go IDLE->DONE, giving o_valid on the first edge after accept (latency 1).
REQ-018 Opcodes 0010/0011 with B!=0 SHALL go IDLE->DIV, run a restoring divider one quotient bit per cycle for M cycles, then enter DONE (o_valid M+1 edges after accept).
REQ-019 Divide by zero SHALL skip DIV with latency 1: quotient all-ones, remainder A, status[2]=1.
REQ-020 Undefined opcodes (1xxx) SHALL give latency 1, result 0 and status[2]=1.
REQ-021 Overflow status[1]: signed overflow of 0000/0001; 0111 with A=100..0 (result SHALL be 100..0); otherwise 0.
REQ-022 Shift amount B >= M SHALL give result 0.
REQ-023 Sign-magnitude negative zero (100..0) under 0110 SHALL give 0 with no overflow.
REQ-024 Flags status[0] and status[3] SHALL be computed from the final o_result for every opcode.
REQ-025 In DONE, o_result and o_status SHALL be held stable until i_ready=1, then return to IDLE on that edge.
REQ-026 There SHALL be one mandatory IDLE cycle between results; there is no back-to-back accept.
REQ-027 In IDLE, o_result and o_status SHALL keep their last value.
REQ-028 In DIV, i_valid SHALL be ignored and o_ready SHALL be 0.

Reset
REQ-029 When i_reset=1 at an edge, from any state, the block SHALL enter IDLE with o_valid=0, o_ready=1, o_result=0, o_status=0 and divider state cleared.
REQ-030 Reset SHALL override a simultaneous accept or i_ready.
REQ-031 Reset during DIV SHALL abort the operation with no result produced.

Verification (M=8)
REQ-032 ADD A=8'h7F, B=8'h01 -> one edge later o_valid=1, o_result=8'h80, o_status=4'b1010.
REQ-033 DIV A=13, B=3 -> o_valid 9 edges after accept, result 8'h04; MOD with the same operands -> 8'h01.
REQ-034 DIV A=5, B=0 -> latency 1, result 8'hFF, o_status=4'b0100.
REQ-035 Conversions: 0110 with A=8'h8A -> 8'hF6; 0111 with A=8'h80 -> 8'h80, status[1]=1; 0110 with A=8'h80 -> 8'h00, status[0]=1.
REQ-036 Hold i_ready=0 for 3 cycles in DONE -> o_valid, o_result, o_status stable and o_ready=0 throughout; i_ready=1 -> IDLE next edge.
REQ-037 Assert i_reset on the 4th DIV cycle -> next edge IDLE, all outputs 0, o_ready=1, and no o_valid pulse.
